// File: rtl/data_mem_unit.sv
// Data-memory unit for the MEM stage: single outstanding request, fixed access latency,
// byte/half/word/double loads and stores with alignment and range checking.
module data_mem_unit #(
   parameter  int unsigned DEPTH   = 128,
   parameter  int unsigned LATENCY = 1,
   localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_write_i,
   input  logic [1:0]       req_size_i,
   input  logic             req_unsigned_i,
   input  logic [63:0]      req_addr_i,
   input  logic [63:0]      req_wdata_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [63:0]      resp_rdata_o,
   output logic             resp_err_o,
   input  logic [IDX_W-1:0] dbg_idx_i,
   output logic [63:0]      dbg_data_o
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   // Simulation-time zero fill; contents are never touched by reset.
   logic [63:0] mem_q [DEPTH] = '{default: '0};

   logic             accept;
   logic [IDX_W-1:0] idx;
   logic [2:0]       off;
   logic [7:0]       lane_mask;
   logic [7:0]       byte_mask;
   logic [63:0]      bit_mask;
   logic             misaligned;
   logic             out_of_range;
   logic             acc_err;
   logic [63:0]      rd_word;
   logic [63:0]      rd_shift;
   logic [63:0]      load_data;
   logic [63:0]      wdata_shift;
   logic             mem_we;

   assign req_ready_o  = (state_q == StIdle) & rst_ni;
   assign accept       = req_valid_i & (state_q == StIdle);
   assign resp_valid_o = (state_q == StResp);
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;
   assign dbg_data_o   = mem_q[dbg_idx_i];

   assign idx          = req_addr_i[IDX_W+2:3];
   assign off          = req_addr_i[2:0];
   assign out_of_range = |req_addr_i[63:IDX_W+3];
   assign acc_err      = misaligned | out_of_range;
   assign rd_word      = mem_q[idx];
   assign rd_shift     = rd_word >> {off, 3'b000};
   assign wdata_shift  = req_wdata_i << {off, 3'b000};
   assign byte_mask    = lane_mask << off;
   assign mem_we       = accept & req_write_i & ~acc_err;

   always_comb begin
      lane_mask  = 8'h01;
      misaligned = 1'b0;
      load_data  = '0;
      unique case (req_size_i)
         2'b00: begin
            lane_mask  = 8'h01;
            misaligned = 1'b0;
            load_data  = req_unsigned_i ? {56'b0, rd_shift[7:0]}
                                        : {{56{rd_shift[7]}}, rd_shift[7:0]};
         end
         2'b01: begin
            lane_mask  = 8'h03;
            misaligned = off[0];
            load_data  = req_unsigned_i ? {48'b0, rd_shift[15:0]}
                                        : {{48{rd_shift[15]}}, rd_shift[15:0]};
         end
         2'b10: begin
            lane_mask  = 8'h0F;
            misaligned = |off[1:0];
            load_data  = req_unsigned_i ? {32'b0, rd_shift[31:0]}
                                        : {{32{rd_shift[31]}}, rd_shift[31:0]};
         end
         default: begin
            lane_mask  = 8'hFF;
            misaligned = |off;
            load_data  = rd_shift;
         end
      endcase
   end

   always_comb begin
      bit_mask = '0;
      for (int b = 0; b < 8; b++) begin
         bit_mask[8*b +: 8] = {8{byte_mask[b]}};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               rdata_d = (acc_err | req_write_i) ? 64'b0 : load_data;
               err_d   = acc_err;
               if (LATENCY == 1) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StResp;
         end
         StResp: begin
            if (resp_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[idx] <= (rd_word & ~bit_mask) | (wdata_shift & bit_mask);
   end

endmodule
